rx_serial_7o1: RTL and testbench
================================

// Module: rx_serial_7O1
//
// PURPOSE
// - Asynchronous serial receiver, 7O1 format: 1 start, 7 data LSB-first,
//   odd parity, 1 stop; line idles high.
// - Inverse end of the trena's serial transmit path.
// - Decodes command characters from the host PC, e.g. to raise "mensurar".
// - Outputs each received character as a parallel word plus a 1-cycle
//   pronto strobe, with parity and framing status.
//
// PARAMETERS
// - M     434  clock cycles per bit (50 MHz / 115200 baud); even, >= 4
// - N_CNT 9    width of the bit-time counter; 2**N_CNT > M
//
// PORTS
// - clock          in   1  system clock, rising edge
// - reset          in   1  asynchronous, active-high
// - dado_serial    in   1  serial line, asynchronous to clock, idle = 1
// - dado_recebido  out  7  last stored character
// - paridade_ok    out  1  1 = last stored frame had odd parity over data+parity
// - erro_parada    out  1  1 = last frame had stop bit = 0 (framing error)
// - pronto         out  1  1-cycle strobe: dado_recebido/paridade_ok updated
// - db_estado      out  4  FSM state code, for debug display
//
// BEHAVIOUR
// - Input sync: dado_serial passes through a 2-FF synchronizer reset to 1;
//   the FSM sees only the synced value s. Two-cycle input latency is part of
//   the spec.
// - Reset values: dado_recebido=0, paridade_ok=0, erro_parada=0, pronto=0,
//   FSM=ocioso, counters=0, shift register=0.
// - FSM states (db_estado code):
//   - ocioso (0): counter held at 0; s==0 -> inicio.
//   - inicio (1): count M/2-1 cycles, then resample s.
//     s==0 -> recepcao, with bit counter=0 and bit-time counter=0.
//     s==1 -> ocioso (glitch reject; no outputs change).
//   - recepcao (2): every M cycles, shift s into the 8-bit shift register
//     (7 data bits, then the parity bit).
//     After the 8th sample -> parada.
//   - parada (3): after M cycles, sample s.
//     s==1 -> armazena.
//     s==0 -> erro (4).
//   - armazena (5): for 1 cycle:
//     - dado_recebido <= shift[6:0]
//     - paridade_ok <= ^shift[7:0]
//     - erro_parada <= 0
//     - pronto = 1
//     Next state: ocioso.
//   - erro (4):
//     - erro_parada <= 1 on entry.
//     - dado_recebido and paridade_ok are kept.
//     - No pronto is issued.
//     - Stays in erro until s==1, then -> ocioso.
//     - A break condition (line held low) therefore never re-triggers.
//   - Unused codes -> ocioso.
// - Sampling point: every sample, including the start check, falls
//   ceil(M/2) +/- 1 cycles after the synced bit edge.
// - Latency: pronto rises exactly 1 cycle after the mid-stop sample.
//   That is about 9.5*M + 3 cycles after the falling edge of start on the
//   dado_serial pin.
// - pronto is a Moore output: high only in armazena, exactly 1 cycle per
//   valid frame.
// - Parity error: the frame is still stored with pronto=1 and
//   paridade_ok=0; the consumer decides whether to discard it.
// - Back-to-back frames: armazena lasts 1 cycle at mid-stop, so a start
//   edge arriving M/2 cycles later is caught in ocioso. No idle gap between
//   frames is required.
// - Reset mid-frame: the FSM returns to ocioso immediately. A partially
//   received frame is discarded, and the receiver resyncs on the next
//   falling edge.
// - Counters saturate never: the bit-time counter clears on every sample
//   and on every state entry.
//
// TESTING (sim with M=8; frames driven bit-by-bit, 8 clocks per bit)
// 1. Reset, line idle 1 for 50 cycles -> all outputs 0, pronto never high,
//    db_estado=0.
// 2. Send 0x35 ('5'; 4 ones, parity=1) -> single pronto pulse;
//    dado_recebido=0x35, paridade_ok=1, erro_parada=0.
// 3. Send 0x41 with parity bit forced 0 -> pronto pulse,
//    dado_recebido=0x41, paridade_ok=0.
// 4. Send 0x6D with stop bit 0, hold line 0 for 30 cycles, then 1 ->
//    no pronto, erro_parada=1, db_estado=4 while low, then 0.
//    Next valid 0x30 -> pronto, erro_parada=0.
// 5. Line low pulse of 2 cycles (glitch) -> returns to ocioso, no pronto,
//    outputs unchanged.
//    Then two frames 0x31, 0x32 back-to-back with no idle gap ->
//    two pronto pulses with the matching data.
// 6. Assert reset during data bit 4 of a frame -> outputs 0, FSM ocioso.
//    Next full frame 0x7F -> pronto, dado_recebido=0x7F, paridade_ok=1.

Source files
------------

// File: rtl/rx_serial_7o1.sv
// ---------------------------------------------------------------------------
// rx_serial_7o1
//
// Asynchronous serial receiver for 7O1 frames: 1 start bit, 7 data bits
// LSB-first, odd parity, 1 stop bit. The line idles high. This is the
// receiving end of the trena serial link. It decodes command characters
// sent by the host PC.
//
// Parameters
//   M      clock cycles per bit time (even, >= 4)
//   N_CNT  width of the bit-time counter (2**N_CNT > M)
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high
//   dado_serial    in   serial line, asynchronous to clock, idle = 1
//   dado_recebido  out  [6:0] last stored character
//   paridade_ok    out  1 = last stored frame had odd parity (data+parity)
//   erro_parada    out  1 = last frame had a stop bit of 0 (framing error)
//   pronto         out  1-cycle strobe; the stored character and parity
//                       status are updated as this strobe ends
//   db_estado      out  [3:0] FSM state code for the debug display
// ---------------------------------------------------------------------------
module rx_serial_7o1 #(
    parameter int M     = 434,
    parameter int N_CNT = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    output logic [6:0] dado_recebido,
    output logic       paridade_ok,
    output logic       erro_parada,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        INICIO   = 4'd1,
        RECEPCAO = 4'd2,
        PARADA   = 4'd3,
        ERRO     = 4'd4,
        ARMAZENA = 4'd5
    } estado_t;

    // Last cycle of the half-bit wait in inicio, and of a full bit time.
    localparam logic [N_CNT-1:0] MEIO = N_CNT'(M / 2 - 1);
    localparam logic [N_CNT-1:0] FIM  = N_CNT'(M - 1);

    logic             sync_a;
    logic             s;
    estado_t          estado;
    estado_t          proximo;
    logic [N_CNT-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             fim_meio;
    logic             fim_bit;

    // Two-flop synchronizer. It resets to the idle level so that reset does
    // not look like a start edge.
    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b1;
            s      <= 1'b1;
        end else begin
            sync_a <= dado_serial;
            s      <= sync_a;
        end
    end

    assign fim_meio = (cnt == MEIO);
    assign fim_bit  = (cnt == FIM);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic and the Moore strobe
    // NOTE: defaults are assigned before the case so that no path leaves
    // an output unassigned, which would infer a latch.
    always_comb begin
        proximo = estado;
        pronto  = 1'b0;
        case (estado)
            OCIOSO: begin
                if (!s) proximo = INICIO;
            end
            INICIO: begin
                // A start that is no longer low at mid-bit was a glitch.
                if (fim_meio) proximo = s ? OCIOSO : RECEPCAO;
            end
            RECEPCAO: begin
                if (fim_bit && bit_cnt == 3'd7) proximo = PARADA;
            end
            PARADA: begin
                if (fim_bit) proximo = s ? ARMAZENA : ERRO;
            end
            ARMAZENA: begin
                pronto  = 1'b1;
                proximo = OCIOSO;
            end
            ERRO: begin
                // Wait for the line to return high so a held break does not
                // look like a stream of start bits.
                if (s) proximo = OCIOSO;
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

    // Bit-time counter. It clears on every state entry, and in recepcao on
    // every sample, so it never needs to wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (proximo != estado) begin
            cnt <= '0;
        end else begin
            case (estado)
                INICIO, PARADA: cnt <= cnt + N_CNT'(1);
                RECEPCAO:       cnt <= fim_bit ? '0 : cnt + N_CNT'(1);
                default:        cnt <= '0;
            endcase
        end
    end

    // Bit counter and shift register. Bits arrive LSB-first, so the shift is
    // to the right. After 8 samples, shift[6:0] holds the data and shift[7]
    // holds the parity bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (estado)
                INICIO: begin
                    bit_cnt <= '0;
                end
                RECEPCAO: begin
                    if (fim_bit) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shift   <= {s, shift[7:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers. A framing error keeps the previous character and
    // parity status and only raises erro_parada.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dado_recebido <= '0;
            paridade_ok   <= 1'b0;
            erro_parada   <= 1'b0;
        end else begin
            if (estado == ARMAZENA) begin
                dado_recebido <= shift[6:0];
                paridade_ok   <= ^shift;
                erro_parada   <= 1'b0;
            end else if (estado == PARADA && fim_bit && !s) begin
                erro_parada <= 1'b1;
            end
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// ---------------------------------------------------------------------------
// tb_rx_serial_7o1
//
// Drives 7O1 frames bit by bit into rx_serial_7o1 with M = 8. Every character
// captured on pronto is compared against the frames the bench sent.
// ---------------------------------------------------------------------------
module tb_rx_serial_7o1;

    localparam int M     = 8;
    localparam int N_CNT = 4;

    logic       clock;
    logic       reset;
    logic       dado_serial;
    logic [6:0] dado_recebido;
    logic       paridade_ok;
    logic       erro_parada;
    logic       pronto;
    logic [3:0] db_estado;

    rx_serial_7o1 #(.M(M), .N_CNT(N_CNT)) dut (
        .clock         (clock),
        .reset         (reset),
        .dado_serial   (dado_serial),
        .dado_recebido (dado_recebido),
        .paridade_ok   (paridade_ok),
        .erro_parada   (erro_parada),
        .pronto        (pronto),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] d;
        logic       p;
        logic       e;
    } cap_t;

    cap_t capq[$];   // what the DUT stored, one entry per pronto pulse
    cap_t expq[$];   // what the reference model says it should have stored
    int   n_cmp = 0;
    int   n_err = 0;
    int   wide  = 0;
    logic pend  = 1'b0;
    logic prev_p = 1'b0;

    // Monitor: take a snapshot of the outputs one cycle after each pronto
    // pulse, and count pronto pulses that last longer than one cycle.
    always @(negedge clock) begin
        if (pend) capq.push_back(cap_t'{dado_recebido, paridade_ok, erro_parada});
        if (pronto && prev_p) wide <= wide + 1;
        pend   <= pronto && !reset;
        prev_p <= pronto;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic odd_par(input logic [6:0] d);
        return ~^d;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic b);
        dado_serial = b;
        tick(M);
    endtask

    // Drive one frame. Frames with a valid stop bit add an expectation to the
    // reference model. The line is odd-parity valid when the number of ones
    // over data and parity is odd.
    task automatic send_frame(input logic [6:0] d, input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(d[i]);
        drive_bit(par_bit);
        drive_bit(stop_bit);
        if (stop_bit)
            expq.push_back(cap_t'{d, ($countones({par_bit, d}) % 2) == 1, 1'b0});
    endtask

    task automatic verify_captures(input string tag);
        cap_t c;
        cap_t e;
        check({tag, "_count"}, capq.size(), expq.size());
        while (capq.size() > 0 && expq.size() > 0) begin
            c = capq.pop_front();
            e = expq.pop_front();
            check({tag, "_data"},   c.d, e.d);
            check({tag, "_parok"},  c.p, e.p);
            check({tag, "_erro"},   c.e, e.e);
        end
        capq.delete();
        expq.delete();
    endtask

    initial begin
        logic [6:0] d;
        logic       corrupt;

        // 1. Reset and idle line
        dado_serial = 1'b1;
        reset       = 1'b1;
        tick(3);
        check("rst_dado",   dado_recebido, 7'h00);
        check("rst_parok",  paridade_ok,   1'b0);
        check("rst_erro",   erro_parada,   1'b0);
        check("rst_pronto", pronto,        1'b0);
        check("rst_estado", db_estado,     4'd0);
        reset = 1'b0;
        tick(50);
        check("idle_dado",   dado_recebido, 7'h00);
        check("idle_parok",  paridade_ok,   1'b0);
        check("idle_erro",   erro_parada,   1'b0);
        check("idle_estado", db_estado,     4'd0);
        check("idle_pulses", capq.size(),   0);

        // 2. Valid character '5'
        send_frame(7'h35, odd_par(7'h35), 1'b1);
        tick(4);
        verify_captures("c35");
        check("c35_out_dado",  dado_recebido, 7'h35);
        check("c35_out_parok", paridade_ok,   1'b1);
        check("c35_out_erro",  erro_parada,   1'b0);

        // 3. Parity bit forced to 0: still stored, parity flagged bad
        send_frame(7'h41, 1'b0, 1'b1);
        tick(4);
        verify_captures("c41");
        check("c41_out_parok", paridade_ok, 1'b0);

        // 4. Framing error followed by a held break
        send_frame(7'h6D, odd_par(7'h6D), 1'b0);
        tick(15);
        check("brk_estado", db_estado,     4'd4);
        check("brk_erro",   erro_parada,   1'b1);
        check("brk_dado",   dado_recebido, 7'h41);
        check("brk_parok",  paridade_ok,   1'b0);
        tick(15);
        check("brk_estado2", db_estado,   4'd4);
        check("brk_pulses",  capq.size(), 0);
        dado_serial = 1'b1;
        tick(5);
        check("brk_release", db_estado, 4'd0);
        send_frame(7'h30, odd_par(7'h30), 1'b1);
        tick(4);
        verify_captures("c30");
        check("c30_out_erro", erro_parada, 1'b0);

        // 5. Short glitch, then two back-to-back frames
        dado_serial = 1'b0;
        tick(2);
        dado_serial = 1'b1;
        tick(20);
        check("glitch_estado", db_estado,     4'd0);
        check("glitch_pulses", capq.size(),   0);
        check("glitch_dado",   dado_recebido, 7'h30);
        send_frame(7'h31, odd_par(7'h31), 1'b1);
        send_frame(7'h32, odd_par(7'h32), 1'b1);
        tick(4);
        verify_captures("b2b");

        // 6. Reset during data bit 4
        d = 7'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        dado_serial = d[4];
        tick(3);
        #2 reset = 1'b1;
        tick(2);
        check("mid_rst_dado",   dado_recebido, 7'h00);
        check("mid_rst_parok",  paridade_ok,   1'b0);
        check("mid_rst_estado", db_estado,     4'd0);
        dado_serial = 1'b1;
        reset       = 1'b0;
        tick(10);
        check("post_rst_estado", db_estado,   4'd0);
        check("post_rst_pulses", capq.size(), 0);
        send_frame(7'h7F, odd_par(7'h7F), 1'b1);
        tick(4);
        verify_captures("c7f");
        check("c7f_out_dado",  dado_recebido, 7'h7F);
        check("c7f_out_parok", paridade_ok,   1'b1);

        // Random frames: random data, some with the parity bit corrupted,
        // random idle gaps (including none)
        for (int k = 0; k < 24; k++) begin
            d       = 7'($urandom_range(0, 127));
            corrupt = ($urandom_range(0, 3) == 0);
            send_frame(d, odd_par(d) ^ corrupt, 1'b1);
            tick($urandom_range(0, 10));
        end
        tick(4);
        verify_captures("rnd");

        check("pronto_width", wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
